// File: rtl/dtcctf_clkctrl.sv
// dtcctf_clkctrl: supervisor for the DTC clock path.
// It qualifies the DTC clock from the measurement strobes, then releases the
// PLL reset and waits for lock. After a settle period it moves the clock mux
// onto the PLL output. Any loss falls back to the local clock and restarts
// qualification.
//
// Build option: DTCCTF_CLKCTRL_RETRY_EN
//   - defined:   a lock timeout returns to S_WAIT and qualification restarts.
//   - undefined: a lock timeout parks the FSM in S_FAIL until reset or until
//                force_local is pulsed.
//
// state    | meaning
// S_WAIT   | local clock, PLL held in reset, counting good strobes
// S_PLLRST | PLL reset held for RST_CYCLES cycles
// S_LOCK   | PLL reset released, waiting for locked_s (bounded by timeout)
// S_SETTLE | lock must stay high for SETTLE_CYCLES before switching
// S_RUN    | mux on DTC PLL clock, watching for loss
// S_FAIL   | lock timed out, sticky (only when retry is disabled)
module dtcctf_clkctrl #(
  parameter logic [15:0] QUAL_COUNT    = 16'd2000,
  parameter logic [7:0]  RST_CYCLES    = 8'd16,
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd50000,
  parameter logic [7:0]  SETTLE_CYCLES = 8'd8
) (
  input  logic       clk0,
  input  logic       rstn,
  input  logic       meas_dv,
  input  logic       meas_ok,
  input  logic       pll_locked,
  input  logic       force_local,
  output logic       pll_rst,
  output logic       clksel,
  output logic [2:0] ctrl_state,
  output logic [7:0] lost_cnt,
  output logic       lost_irq
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_PLLRST = 3'd1,
    S_LOCK   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_locked_s;
  logic [15:0] r_qual_cnt;
  logic [15:0] r_timer;

  state_t      w_nxt_state;
  logic        w_good;
  logic        w_bad;
  logic        w_loss;
  logic        w_qual_inc;
  logic        w_pll_rst_nxt;

  assign w_good = meas_dv & meas_ok;
  assign w_bad  = meas_dv & ~meas_ok;

  assign ctrl_state = r_state;

  // Next-state decision; force_local overrides everything, then loss/abort,
  // then timeout, then normal progress.
  always_comb begin
    w_nxt_state = r_state;
    w_loss      = 1'b0;
    w_qual_inc  = 1'b0;
    if (force_local) begin
      w_nxt_state = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_good) begin
            if (r_qual_cnt == (QUAL_COUNT - 16'd1)) w_nxt_state = S_PLLRST;
            else                                    w_qual_inc  = 1'b1;
          end
        end
        S_PLLRST: begin
          if (r_timer == {8'd0, RST_CYCLES - 8'd1}) w_nxt_state = S_LOCK;
        end
        S_LOCK: begin
          if (w_bad) begin
            w_nxt_state = S_WAIT;
          end else if (r_timer == (LOCK_TIMEOUT - 16'd1)) begin
`ifdef DTCCTF_CLKCTRL_RETRY_EN
            w_nxt_state = S_WAIT;
`else
            w_nxt_state = S_FAIL;
`endif
          end else if (r_locked_s) begin
            w_nxt_state = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_bad || !r_locked_s)                        w_nxt_state = S_WAIT;
          else if (r_timer == {8'd0, SETTLE_CYCLES - 8'd1}) w_nxt_state = S_RUN;
        end
        S_RUN: begin
          if (w_bad || !r_locked_s) begin
            w_nxt_state = S_WAIT;
            w_loss      = 1'b1;
          end
        end
        S_FAIL:  w_nxt_state = S_FAIL;
        default: w_nxt_state = S_WAIT;
      endcase
    end
  end

  // PLL reset is asserted whenever the PLL output is not being waited on or used.
  assign w_pll_rst_nxt = (w_nxt_state == S_WAIT) || (w_nxt_state == S_PLLRST) ||
                         (w_nxt_state == S_FAIL);

  // State, lock synchronizer, counters and registered outputs decoded from next state.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_WAIT;
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
      r_qual_cnt <= 16'd0;
      r_timer    <= 16'd0;
      pll_rst    <= 1'b1;
      clksel     <= 1'b0;
      lost_cnt   <= 8'd0;
      lost_irq   <= 1'b0;
    end else begin
      r_sync1    <= pll_locked;
      r_locked_s <= r_sync1;
      r_state    <= w_nxt_state;
      pll_rst    <= w_pll_rst_nxt;
      clksel     <= (w_nxt_state == S_RUN);
      lost_irq   <= w_loss;
      if (w_loss && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 8'd1;

      if (force_local || (w_nxt_state != r_state)) begin
        r_qual_cnt <= 16'd0;
        r_timer    <= 16'd0;
      end else if (r_state == S_WAIT) begin
        if (w_qual_inc)  r_qual_cnt <= r_qual_cnt + 16'd1;
        else if (w_bad)  r_qual_cnt <= 16'd0;
      end else if ((r_state == S_PLLRST) || (r_state == S_LOCK) ||
                   (r_state == S_SETTLE)) begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dtcctf_clkctrl.sv
// Directed bench for dtcctf_clkctrl with small parameters
// (QUAL_COUNT=4, RST_CYCLES=3, LOCK_TIMEOUT=20, SETTLE_CYCLES=2).
module tb_dtcctf_clkctrl;

  logic       clk0;
  logic       rstn;
  logic       meas_dv;
  logic       meas_ok;
  logic       pll_locked;
  logic       force_local;
  logic       pll_rst;
  logic       clksel;
  logic [2:0] ctrl_state;
  logic [7:0] lost_cnt;
  logic       lost_irq;

  int n_vec = 0;
  int n_err = 0;

  dtcctf_clkctrl #(
    .QUAL_COUNT   (16'd4),
    .RST_CYCLES   (8'd3),
    .LOCK_TIMEOUT (16'd20),
    .SETTLE_CYCLES(8'd2)
  ) dut (
    .clk0       (clk0),
    .rstn       (rstn),
    .meas_dv    (meas_dv),
    .meas_ok    (meas_ok),
    .pll_locked (pll_locked),
    .force_local(force_local),
    .pll_rst    (pll_rst),
    .clksel     (clksel),
    .ctrl_state (ctrl_state),
    .lost_cnt   (lost_cnt),
    .lost_irq   (lost_irq)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic ok);
    meas_dv = 1'b1;
    meas_ok = ok;
    tick();
    meas_dv = 1'b0;
    meas_ok = 1'b0;
  endtask

  task automatic qualify();
    for (int i = 0; i < 4; i++) strobe(1'b1);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && ctrl_state != 3'd4; i++) tick();
    chk("run_reached", {13'd0, ctrl_state}, 16'd4);
  endtask

  initial begin
    rstn = 1'b0; meas_dv = 1'b0; meas_ok = 1'b0; pll_locked = 1'b0; force_local = 1'b0;
    tick(); tick(); tick();
    chk("rst_state",   {13'd0, ctrl_state}, 16'd0);
    chk("rst_pll_rst", {15'd0, pll_rst},    16'd1);
    chk("rst_clksel",  {15'd0, clksel},     16'd0);
    chk("rst_lostcnt", {8'd0, lost_cnt},    16'd0);
    chk("rst_lostirq", {15'd0, lost_irq},   16'd0);
    rstn = 1'b1;
    tick();

    // 3 good, 1 bad, 3 good: still waiting; 8th strobe enters S_PLLRST
    strobe(1'b1); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    chk("qual_7th", {13'd0, ctrl_state}, 16'd0);
    strobe(1'b1);
    chk("qual_8th", {13'd0, ctrl_state}, 16'd1);
    chk("pllrst_c1", {15'd0, pll_rst}, 16'd1);
    pll_locked = 1'b0;
    tick();
    chk("pllrst_c2", {13'd0, ctrl_state}, 16'd1);
    tick();
    chk("pllrst_c3", {13'd0, ctrl_state}, 16'd1);
    chk("pllrst_c3_rst", {15'd0, pll_rst}, 16'd1);
    tick();
    chk("lock_entry", {13'd0, ctrl_state}, 16'd2);
    chk("lock_pll_rst", {15'd0, pll_rst}, 16'd0);
    pll_locked = 1'b1;
    tick(); tick();
    chk("lock_sync", {13'd0, ctrl_state}, 16'd2);
    tick();
    chk("settle_1", {13'd0, ctrl_state}, 16'd3);
    chk("settle_clksel", {15'd0, clksel}, 16'd0);
    tick();
    chk("settle_2", {13'd0, ctrl_state}, 16'd3);
    tick();
    chk("run_state", {13'd0, ctrl_state}, 16'd4);
    chk("run_clksel", {15'd0, clksel}, 16'd1);
    chk("run_pll_rst", {15'd0, pll_rst}, 16'd0);

    // Loss by bad strobe
    strobe(1'b0);
    chk("loss1_state", {13'd0, ctrl_state}, 16'd0);
    chk("loss1_clksel", {15'd0, clksel}, 16'd0);
    chk("loss1_pll_rst", {15'd0, pll_rst}, 16'd1);
    chk("loss1_irq", {15'd0, lost_irq}, 16'd1);
    chk("loss1_cnt", {8'd0, lost_cnt}, 16'd1);
    tick();
    chk("loss1_irq_off", {15'd0, lost_irq}, 16'd0);

    // Loss through lock: clksel drops 3 edges after pll_locked falls
    qualify();
    wait_run();
    pll_locked = 1'b0;
    tick(); tick();
    chk("lockloss_e2", {13'd0, ctrl_state}, 16'd4);
    tick();
    chk("lockloss_e3", {13'd0, ctrl_state}, 16'd0);
    chk("lockloss_clksel", {15'd0, clksel}, 16'd0);
    chk("lockloss_irq", {15'd0, lost_irq}, 16'd1);
    chk("lockloss_cnt", {8'd0, lost_cnt}, 16'd2);
    pll_locked = 1'b1;
    tick(); tick();

    // Simultaneous bad strobe and lock fall count once
    qualify();
    wait_run();
    pll_locked = 1'b0;
    tick(); tick();
    chk("simul_pre", {13'd0, ctrl_state}, 16'd4);
    strobe(1'b0);
    chk("simul_state", {13'd0, ctrl_state}, 16'd0);
    chk("simul_cnt", {8'd0, lost_cnt}, 16'd3);
    chk("simul_irq", {15'd0, lost_irq}, 16'd1);
    tick();
    chk("simul_cnt2", {8'd0, lost_cnt}, 16'd3);
    chk("simul_irq2", {15'd0, lost_irq}, 16'd0);
    pll_locked = 1'b1;
    tick(); tick();

    // force_local from S_RUN
    qualify();
    wait_run();
    force_local = 1'b1;
    tick();
    chk("force_state", {13'd0, ctrl_state}, 16'd0);
    chk("force_clksel", {15'd0, clksel}, 16'd0);
    chk("force_pll_rst", {15'd0, pll_rst}, 16'd1);
    chk("force_irq", {15'd0, lost_irq}, 16'd0);
    chk("force_cnt", {8'd0, lost_cnt}, 16'd3);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    chk("force_ignore", {13'd0, ctrl_state}, 16'd0);
    pll_locked = 1'b0;
    tick(); tick();
    force_local = 1'b0;
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    chk("rel_qual3", {13'd0, ctrl_state}, 16'd0);
    strobe(1'b1);
    chk("rel_qual4", {13'd0, ctrl_state}, 16'd1);

    // Lock timeout with pll_locked held low
    tick(); tick(); tick();
    chk("to_lock", {13'd0, ctrl_state}, 16'd2);
    for (int i = 0; i < 19; i++) tick();
    chk("to_last", {13'd0, ctrl_state}, 16'd2);
    tick();
`ifdef DTCCTF_CLKCTRL_RETRY_EN
    chk("to_retry", {13'd0, ctrl_state}, 16'd0);
    chk("to_pll_rst", {15'd0, pll_rst}, 16'd1);
    chk("to_irq", {15'd0, lost_irq}, 16'd0);
    chk("to_cnt", {8'd0, lost_cnt}, 16'd3);
    qualify();
    chk("to_requal", {13'd0, ctrl_state}, 16'd1);
    force_local = 1'b1;
    tick();
    chk("to_force", {13'd0, ctrl_state}, 16'd0);
    force_local = 1'b0;
    tick();
`else
    chk("to_fail", {13'd0, ctrl_state}, 16'd5);
    chk("to_pll_rst", {15'd0, pll_rst}, 16'd1);
    chk("to_irq", {15'd0, lost_irq}, 16'd0);
    chk("to_cnt", {8'd0, lost_cnt}, 16'd3);
    tick(); tick(); tick();
    chk("fail_sticky", {13'd0, ctrl_state}, 16'd5);
    qualify();
    chk("fail_strobes", {13'd0, ctrl_state}, 16'd5);
    chk("fail_clksel", {15'd0, clksel}, 16'd0);
    force_local = 1'b1;
    tick();
    chk("fail_force", {13'd0, ctrl_state}, 16'd0);
    force_local = 1'b0;
    tick();
    chk("fail_release", {13'd0, ctrl_state}, 16'd0);
`endif
    chk("post_to_cnt", {8'd0, lost_cnt}, 16'd3);
    pll_locked = 1'b1;
    tick(); tick();

    // Saturation: 252 more losses reach 255, further losses hold at 255
    for (int k = 0; k < 252; k++) begin
      qualify();
      wait_run();
      strobe(1'b0);
    end
    chk("sat_255", {8'd0, lost_cnt}, 16'd255);
    for (int k = 0; k < 5; k++) begin
      qualify();
      wait_run();
      strobe(1'b0);
    end
    chk("sat_hold", {8'd0, lost_cnt}, 16'd255);
    chk("sat_irq", {15'd0, lost_irq}, 16'd1);

    // Async reset in the middle of S_LOCK
    pll_locked = 1'b0;
    tick(); tick();
    qualify();
    tick(); tick(); tick();
    chk("ar_lock", {13'd0, ctrl_state}, 16'd2);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_state",   {13'd0, ctrl_state}, 16'd0);
    chk("ar_pll_rst", {15'd0, pll_rst},    16'd1);
    chk("ar_clksel",  {15'd0, clksel},     16'd0);
    chk("ar_cnt",     {8'd0, lost_cnt},    16'd0);
    chk("ar_irq",     {15'd0, lost_irq},   16'd0);
    tick();
    rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
